// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter.
//   Frame = start(0), N data bits LSB first (N=5..8), optional odd/even
//   parity, 1 or 2 stop bits. Each bit is held for D clocks (D from
//   i_Clks_Per_Bit, 0 treated as 1). The byte, divisor and frame format
//   are captured on the accept edge (i_Tx_DV && o_Tx_Ready). Later input
//   changes do not affect the frame in flight.
// Ports:
//   i_Clock, i_Reset          clock, async active-high reset
//   i_Clks_Per_Bit            clocks per serial bit
//   i_Cfg_Data_Bits           data bits minus 5
//   i_Cfg_Parity              00/11 none, 01 odd, 10 even
//   i_Cfg_Stop2               1 = two stop bits
//   i_Tx_DV, i_Tx_Byte        byte handshake input
//   o_Tx_Ready                byte can be accepted this cycle
//   o_Tx_Active               frame in progress (start .. last stop clock)
//   o_Tx_Serial               serial line, idle high
//   o_Tx_Done                 one-cycle pulse after the last stop clock
module uart_tx_cfg #(
   parameter int DIV_WIDTH = 16,
   parameter int RESET_DIV = 87
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
   input  logic [1:0]           i_Cfg_Data_Bits,
   input  logic [1:0]           i_Cfg_Parity,
   input  logic                 i_Cfg_Stop2,
   input  logic                 i_Tx_DV,
   input  logic [7:0]           i_Tx_Byte,
   output logic                 o_Tx_Ready,
   output logic                 o_Tx_Active,
   output logic                 o_Tx_Serial,
   output logic                 o_Tx_Done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

   state_t               state_q, state_d;
   logic [DIV_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]           bit_cnt_q, bit_cnt_d;
   logic [7:0]           data_q, data_d;
   logic [DIV_WIDTH-1:0] div_q, div_d;
   logic [1:0]           nbits_q, nbits_d;
   logic [1:0]           par_q, par_d;
   logic                 stop2_q, stop2_d;
   logic                 serial_q, serial_d;
   logic                 ready_q, ready_d;
   logic                 active_q, active_d;
   logic                 done_q, done_d;

   logic                 accept;
   logic                 bit_tick;
   logic                 last_data;
   logic                 par_en;
   logic                 par_bit;
   logic                 load;
   logic [7:0]           data_mask;

   always_comb begin
      accept    = i_Tx_DV && ready_q;
      bit_tick  = (clk_cnt_q == div_q - ONE);
      last_data = (bit_cnt_q == (3'd4 + {1'b0, nbits_q}));
      par_en    = (par_q == 2'b01) || (par_q == 2'b10);

      case (nbits_q)
         2'd0:    data_mask = 8'h1F;
         2'd1:    data_mask = 8'h3F;
         2'd2:    data_mask = 8'h7F;
         default: data_mask = 8'hFF;
      endcase
      // even parity bit = XOR of the data bits; odd is its inverse
      par_bit = (^(data_q & data_mask)) ^ (par_q == 2'b01);

      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      data_d    = data_q;
      div_d     = div_q;
      nbits_d   = nbits_q;
      par_d     = par_q;
      stop2_d   = stop2_q;
      done_d    = 1'b0;
      load      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) load = 1'b1;
         end
         S_START: begin
            if (bit_tick) begin
               state_d   = S_DATA;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
            end else begin
               clk_cnt_d = clk_cnt_q + ONE;
            end
         end
         S_DATA: begin
            if (bit_tick) begin
               clk_cnt_d = '0;
               if (last_data) begin
                  bit_cnt_d = '0;
                  state_d   = par_en ? S_PARITY : S_STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + ONE;
            end
         end
         S_PARITY: begin
            if (bit_tick) begin
               state_d   = S_STOP;
               clk_cnt_d = '0;
               bit_cnt_d = '0;
            end else begin
               clk_cnt_d = clk_cnt_q + ONE;
            end
         end
         S_STOP: begin
            // bit_cnt indexes the stop bit here (0, or 0..1 with two stops)
            if (bit_tick) begin
               clk_cnt_d = '0;
               if (bit_cnt_q == {2'b00, stop2_q}) begin
                  done_d = 1'b1;
                  if (accept) load = 1'b1;
                  else        state_d = S_IDLE;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               clk_cnt_d = clk_cnt_q + ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (load) begin
         state_d   = S_START;
         clk_cnt_d = '0;
         bit_cnt_d = '0;
         data_d    = i_Tx_Byte;
         div_d     = (i_Clks_Per_Bit == '0) ? ONE : i_Clks_Per_Bit;
         nbits_d   = i_Cfg_Data_Bits;
         par_d     = i_Cfg_Parity;
         stop2_d   = i_Cfg_Stop2;
      end

      // Outputs are registered, so they are derived from the next state.
      // Ready rises one clock early, in the last clock of the final stop
      // bit, so a byte offered then starts with no idle gap.
      ready_d  = (state_d == S_IDLE) ||
                 ((state_d == S_STOP) && (bit_cnt_d == {2'b00, stop2_d}) &&
                  (clk_cnt_d == div_d - ONE));
      active_d = (state_d != S_IDLE);

      case (state_d)
         S_START:  serial_d = 1'b0;
         S_DATA:   serial_d = data_d[bit_cnt_d];
         S_PARITY: serial_d = par_bit;
         default:  serial_d = 1'b1;
      endcase
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q   <= S_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         // divisor is always reloaded on accept; its reset value is inert
         div_q     <= DIV_WIDTH'(RESET_DIV);
         nbits_q   <= 2'd3;
         par_q     <= 2'd0;
         stop2_q   <= 1'b0;
         serial_q  <= 1'b1;
         ready_q   <= 1'b1;
         active_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         data_q    <= data_d;
         div_q     <= div_d;
         nbits_q   <= nbits_d;
         par_q     <= par_d;
         stop2_q   <= stop2_d;
         serial_q  <= serial_d;
         ready_q   <= ready_d;
         active_q  <= active_d;
         done_q    <= done_d;
      end
   end

   assign o_Tx_Ready  = ready_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg. Expected line waveforms are written
// as strings, one character per bit in transmit order.
module tb_uart_tx_cfg;

   logic        i_Clock = 1'b0;
   logic        i_Reset;
   logic [15:0] i_Clks_Per_Bit;
   logic [1:0]  i_Cfg_Data_Bits;
   logic [1:0]  i_Cfg_Parity;
   logic        i_Cfg_Stop2;
   logic        i_Tx_DV;
   logic [7:0]  i_Tx_Byte;
   logic        o_Tx_Ready;
   logic        o_Tx_Active;
   logic        o_Tx_Serial;
   logic        o_Tx_Done;

   int checks = 0;
   int errors = 0;

   uart_tx_cfg #(.DIV_WIDTH(16), .RESET_DIV(87)) dut (
      .i_Clock         (i_Clock),
      .i_Reset         (i_Reset),
      .i_Clks_Per_Bit  (i_Clks_Per_Bit),
      .i_Cfg_Data_Bits (i_Cfg_Data_Bits),
      .i_Cfg_Parity    (i_Cfg_Parity),
      .i_Cfg_Stop2     (i_Cfg_Stop2),
      .i_Tx_DV         (i_Tx_DV),
      .i_Tx_Byte       (i_Tx_Byte),
      .o_Tx_Ready      (o_Tx_Ready),
      .o_Tx_Active     (o_Tx_Active),
      .o_Tx_Serial     (o_Tx_Serial),
      .o_Tx_Done       (o_Tx_Done)
   );

   always #5 i_Clock = ~i_Clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Send one byte and follow its frame clock by clock. Right after the
   // accept edge the byte/config inputs are scrambled and a DV pulse is
   // injected while busy; neither may disturb the frame.
   task automatic frame(input string tag, input logic [7:0] b, input logic [1:0] nb,
                        input logic [1:0] par, input logic st2, input logic [15:0] d,
                        input string wave);
      int deff, total, ser_bad, rdy_bad, act_bad, done_bad;
      logic exp_ser;
      deff  = (d == 16'd0) ? 1 : int'(d);
      total = wave.len() * deff;
      ser_bad = 0; rdy_bad = 0; act_bad = 0; done_bad = 0;
      @(negedge i_Clock);
      i_Tx_Byte = b; i_Cfg_Data_Bits = nb; i_Cfg_Parity = par;
      i_Cfg_Stop2 = st2; i_Clks_Per_Bit = d; i_Tx_DV = 1'b1;
      for (int k = 0; k < total; k++) begin
         @(negedge i_Clock);
         exp_ser = (wave[k / deff] == "1");
         if (o_Tx_Serial !== exp_ser) ser_bad++;
         if (o_Tx_Ready !== (k == total - 1)) rdy_bad++;
         if (o_Tx_Active !== 1'b1) act_bad++;
         if (o_Tx_Done !== 1'b0) done_bad++;
         if (k == 0) begin
            i_Tx_DV = 1'b0;
            i_Tx_Byte = ~b; i_Cfg_Data_Bits = ~nb; i_Cfg_Parity = ~par;
            i_Cfg_Stop2 = ~st2; i_Clks_Per_Bit = d + 16'd3;
         end
         if (k == 2) i_Tx_DV = 1'b1;
         if (k == 3) i_Tx_DV = 1'b0;
      end
      check({tag, ".serial_bad"}, ser_bad, 0);
      check({tag, ".ready_bad"}, rdy_bad, 0);
      check({tag, ".active_bad"}, act_bad, 0);
      check({tag, ".early_done"}, done_bad, 0);
      @(negedge i_Clock);
      check({tag, ".done_pulse"}, o_Tx_Done, 1);
      check({tag, ".end_state"}, {o_Tx_Active, o_Tx_Ready, o_Tx_Serial}, 3'b011);
      @(negedge i_Clock);
      check({tag, ".done_low"}, o_Tx_Done, 0);
   endtask

   initial begin
      string wave3;
      int ser_bad, act_bad, done_cnt, done_pos_bad, rdy_bad;

      i_Reset = 1'b1; i_Tx_DV = 1'b0; i_Tx_Byte = 8'h00;
      i_Clks_Per_Bit = 16'd4; i_Cfg_Data_Bits = 2'd3; i_Cfg_Parity = 2'd0; i_Cfg_Stop2 = 1'b0;
      repeat (3) @(negedge i_Clock);
      check("rst.serial", o_Tx_Serial, 1);
      check("rst.ready", o_Tx_Ready, 1);
      check("rst.active", o_Tx_Active, 0);
      check("rst.done", o_Tx_Done, 0);
      #2 i_Reset = 1'b0;

      // 8N1 D=4 0xA5: 40 clocks, Done 41 clocks after accept
      frame("t1_8n1", 8'hA5, 2'd3, 2'b00, 1'b0, 16'd4, "0101001011");
      // 7E2 D=3 0x41: parity 0, two stops, 33 clocks
      frame("t2_7e2", 8'h41, 2'd2, 2'b10, 1'b1, 16'd3, "01000001011");
      // 8O1 D=2 0x41: parity 1
      frame("t3_8o1", 8'h41, 2'd3, 2'b01, 1'b0, 16'd2, "01000001011");
      // 5N1 D=2 0x41: upper bits dropped
      frame("t3_5n1", 8'h41, 2'd0, 2'b00, 1'b0, 16'd2, "0100001");
      // D=0 behaves as D=1; 5N1 0x1A
      frame("t6_d0", 8'h1A, 2'd0, 2'b00, 1'b0, 16'd0, "0010111");
      // D=1, 6E1 0x2D: four ones -> parity 0
      frame("t6_d1", 8'h2D, 2'd1, 2'b10, 1'b0, 16'd1, "010110101");
      // reserved parity code 11 sends no parity bit
      frame("t6_p11", 8'h0F, 2'd0, 2'b11, 1'b0, 16'd1, "0111101");

      // Back-to-back: DV held, 0x11/0x22/0x33, 8N1 D=5
      wave3 = {"0100010001", "0010001001", "0110011001"};
      ser_bad = 0; act_bad = 0; done_cnt = 0; done_pos_bad = 0; rdy_bad = 0;
      @(negedge i_Clock);
      i_Cfg_Data_Bits = 2'd3; i_Cfg_Parity = 2'd0; i_Cfg_Stop2 = 1'b0;
      i_Clks_Per_Bit = 16'd5; i_Tx_Byte = 8'h11; i_Tx_DV = 1'b1;
      for (int k = 0; k <= 150; k++) begin
         @(negedge i_Clock);
         if (k < 150 && o_Tx_Serial !== (wave3[k / 5] == "1")) ser_bad++;
         if (o_Tx_Active !== (k < 150)) act_bad++;
         if (o_Tx_Done === 1'b1) done_cnt++;
         if (o_Tx_Done !== (k == 50 || k == 100 || k == 150)) done_pos_bad++;
         if (o_Tx_Ready !== (k == 49 || k == 99 || k >= 149)) rdy_bad++;
         if (k == 0)   i_Tx_Byte = 8'h22;
         if (k == 50)  i_Tx_Byte = 8'h33;
         if (k == 100) i_Tx_DV = 1'b0;
      end
      check("b2b.serial_bad", ser_bad, 0);
      check("b2b.active_bad", act_bad, 0);
      check("b2b.done_count", done_cnt, 3);
      check("b2b.done_pos_bad", done_pos_bad, 0);
      check("b2b.ready_bad", rdy_bad, 0);

      // Reset mid-data of 0x00, D=8
      @(negedge i_Clock);
      i_Tx_Byte = 8'h00; i_Clks_Per_Bit = 16'd8; i_Tx_DV = 1'b1;
      @(negedge i_Clock);
      i_Tx_DV = 1'b0;
      repeat (20) @(negedge i_Clock);
      check("rst_mid.data_bit", o_Tx_Serial, 0);
      check("rst_mid.busy", o_Tx_Ready, 0);
      #2 i_Reset = 1'b1;
      #1;
      check("rst_mid.serial", o_Tx_Serial, 1);
      check("rst_mid.ready", o_Tx_Ready, 1);
      check("rst_mid.active", o_Tx_Active, 0);
      check("rst_mid.done", o_Tx_Done, 0);
      @(negedge i_Clock);
      #2 i_Reset = 1'b0;
      done_cnt = 0;
      repeat (12) begin
         @(negedge i_Clock);
         if (o_Tx_Done === 1'b1) done_cnt++;
      end
      check("rst_mid.no_done", done_cnt, 0);
      frame("t5_after_rst", 8'h5A, 2'd3, 2'b00, 1'b0, 16'd2, "0010110101");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
